// File: rtl/flash_spi_target.sv
// Single-SPI mode-0 NOR flash responder backed by an external byte RAM.
// Over-samples SPI pins in i_Clk and runs a W25Q-style command subset.
`timescale 1ns/1ps
module flash_spi_target #(
  parameter int ADDR_BITS = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_SPI_nCS,
  input  logic                 i_SPI_Clk,
  input  logic                 i_SPI_MOSI,
  output logic                 o_SPI_MISO,
  output logic                 o_SPI_MISO_OE,
  output logic [ADDR_BITS-1:0] o_Mem_Addr,
  output logic                 o_Mem_Rd,
  output logic                 o_Mem_Wr,
  output logic [7:0]           o_Mem_WrData,
  input  logic [7:0]           i_Mem_RdData,
  output logic                 o_Busy
);

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_CE1  = 8'hC7;
  localparam logic [7:0] OP_CE2  = 8'h60;
  localparam logic [ADDR_BITS-1:0] ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] SEC_MASK = ~ADDR_BITS'(4095);

  typedef enum logic [2:0] {
    ST_IDLE, ST_OPCODE, ST_ADDR, ST_DIN, ST_DOUT, ST_IGNORE
  } state_e;

  logic ncs_meta_q, ncs_sync_q, ncs_prev_q;
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      ncs_meta_q  <= 1'b1;
      ncs_sync_q  <= 1'b1;
      ncs_prev_q  <= 1'b1;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      ncs_meta_q  <= i_SPI_nCS;
      ncs_sync_q  <= ncs_meta_q;
      ncs_prev_q  <= ncs_sync_q;
      sck_meta_q  <= i_SPI_Clk;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= i_SPI_MOSI;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  logic sck_rise, sck_fall, ncs_rise, ncs_fall;
  assign sck_rise = sck_sync_q & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q & sck_prev_q;
  assign ncs_rise = ncs_sync_q & ~ncs_prev_q;
  assign ncs_fall = ~ncs_sync_q & ncs_prev_q;

  state_e               state_q, state_d;
  logic [7:0]           op_q, op_d;
  logic [6:0]           sh_q, sh_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [5:0]           frame_q, frame_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           tx_q, tx_d;
  logic [2:0]           tx_cnt_q, tx_cnt_d;
  logic                 miso_q, miso_d;
  logic                 wel_q, wel_d;
  logic                 mem_rd_q, mem_rd_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic                 pp_rd_q, pp_rd_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 pp_pend_q, pp_pend_d;
  logic [7:0]           pp_byte_q, pp_byte_d;
  logic [7:0]           rd_buf_q, rd_buf_d;
  logic                 ers_q, ers_d;
  logic                 ers_chip_q, ers_chip_d;
  logic [ADDR_BITS-1:0] ers_addr_q, ers_addr_d;

  logic [7:0]           sr1, rx_byte, tx_byte;
  logic [ADDR_BITS-1:0] addr_new;
  logic                 ers_last;

  assign sr1      = {6'b0, wel_q, ers_q};
  assign rx_byte  = {sh_q, mosi_sync_q};
  assign addr_new = {addr_q[ADDR_BITS-2:0], mosi_sync_q};
  assign ers_last = ers_chip_q ? (&ers_addr_q) : (&ers_addr_q[11:0]);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    tx_cnt_d   = tx_cnt_q;
    miso_d     = miso_q;
    wel_d      = wel_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    pp_rd_d    = 1'b0;
    rd_pend_d  = mem_rd_q;
    pp_pend_d  = mem_rd_q & pp_rd_q;
    pp_byte_d  = pp_byte_q;
    rd_buf_d   = rd_buf_q;
    ers_d      = ers_q;
    ers_chip_d = ers_chip_q;
    ers_addr_d = ers_addr_q;
    tx_byte    = (op_q == OP_RDSR) ? sr1 : rd_buf_q;

    if (rd_pend_q) rd_buf_d = i_Mem_RdData;

    if (ers_q) begin
      ers_addr_d = ers_addr_q + ONE;
      if (ers_last) begin
        ers_d = 1'b0;
        wel_d = 1'b0;
      end
    end

    if (ncs_sync_q) begin
      // Frame end: length-qualified commands commit here
      if (ncs_rise && state_q != ST_IDLE) begin
        if (op_q == OP_WREN && frame_q == 6'd8) wel_d = 1'b1;
        if (op_q == OP_WRDI && frame_q == 6'd8) wel_d = 1'b0;
        if (op_q == OP_PP) wel_d = 1'b0;
        if (op_q == OP_SE && frame_q == 6'd32 && wel_q) begin
          ers_d      = 1'b1;
          ers_chip_d = 1'b0;
          ers_addr_d = addr_q & SEC_MASK;
        end
        if ((op_q == OP_CE1 || op_q == OP_CE2) &&
            frame_q == 6'd8 && wel_q) begin
          ers_d      = 1'b1;
          ers_chip_d = 1'b1;
          ers_addr_d = '0;
        end
      end
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else if (ncs_fall) begin
      state_d   = ST_OPCODE;
      bit_cnt_d = '0;
      frame_d   = '0;
    end else begin
      if (sck_rise && state_q != ST_IDLE) begin
        sh_d      = {sh_q[5:0], mosi_sync_q};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (frame_q != 6'h3F) frame_d = frame_q + 6'd1;
        unique case (state_q)
          ST_OPCODE: begin
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              op_d      = rx_byte;
              tx_cnt_d  = '0;
              if (ers_q && rx_byte != OP_RDSR) begin
                op_d    = 8'h00;
                state_d = ST_IGNORE;
              end else begin
                case (rx_byte)
                  OP_READ, OP_PP, OP_SE: state_d = ST_ADDR;
                  OP_RDSR:               state_d = ST_DOUT;
                  default:               state_d = ST_IGNORE;
                endcase
              end
            end
          end
          ST_ADDR: begin
            addr_d = addr_new;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              case (op_q)
                OP_READ: begin
                  mem_rd_d   = 1'b1;
                  mem_addr_d = addr_new;
                  addr_d     = addr_new + ONE;
                  state_d    = ST_DOUT;
                end
                OP_PP:   state_d = ST_DIN;
                default: state_d = ST_IGNORE;
              endcase
            end
          end
          ST_DIN: begin
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              if (wel_q) begin
                mem_rd_d    = 1'b1;
                pp_rd_d     = 1'b1;
                mem_addr_d  = addr_q;
                pp_byte_d   = rx_byte;
                addr_d[7:0] = addr_q[7:0] + 8'd1;
              end
            end
          end
          ST_DOUT: begin
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              if (op_q == OP_READ) begin
                mem_rd_d   = 1'b1;
                mem_addr_d = addr_q;
                addr_d     = addr_q + ONE;
              end
            end
          end
          default: ;
        endcase
      end
      if (sck_fall && state_q == ST_DOUT) begin
        tx_cnt_d = tx_cnt_q + 3'd1;
        if (tx_cnt_q == 3'd0) begin
          miso_d = tx_byte[7];
          tx_d   = {tx_byte[6:0], 1'b0};
        end else begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      addr_q     <= '0;
      tx_q       <= '0;
      tx_cnt_q   <= '0;
      miso_q     <= 1'b0;
      wel_q      <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      pp_rd_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      pp_pend_q  <= 1'b0;
      pp_byte_q  <= '0;
      rd_buf_q   <= '0;
      ers_q      <= 1'b0;
      ers_chip_q <= 1'b0;
      ers_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      tx_cnt_q   <= tx_cnt_d;
      miso_q     <= miso_d;
      wel_q      <= wel_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      pp_rd_q    <= pp_rd_d;
      rd_pend_q  <= rd_pend_d;
      pp_pend_q  <= pp_pend_d;
      pp_byte_q  <= pp_byte_d;
      rd_buf_q   <= rd_buf_d;
      ers_q      <= ers_d;
      ers_chip_q <= ers_chip_d;
      ers_addr_q <= ers_addr_d;
    end
  end

  // Program write lands the cycle the old byte is on i_Mem_RdData
  assign o_Mem_Wr     = ers_q | pp_pend_q;
  assign o_Mem_WrData = ers_q ? 8'hFF :
                        (pp_pend_q ? (i_Mem_RdData & pp_byte_q) : 8'h00);
  assign o_Mem_Addr   = ers_q ? ers_addr_q : mem_addr_q;
  assign o_Mem_Rd     = mem_rd_q;
  assign o_SPI_MISO   = miso_q;
  assign o_SPI_MISO_OE = (state_q == ST_DOUT);
  assign o_Busy       = ers_q;

endmodule

// File: tb/tb_flash_spi_target.sv
// Scoreboard bench for flash_spi_target: MISO bytes checked by a monitor,
// memory and status effects checked against hand-computed values.
`timescale 1ns/1ps
module tb_flash_spi_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ncs = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        miso, oe, mrd, mwr, busy;
  logic [15:0] maddr;
  logic [7:0]  wdata;
  logic [7:0]  rdata = 8'h00;

  logic [7:0]  mem [0:65535];
  int          wr_cnt = 0;
  logic        preload = 1'b0;
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  int          n_chk = 0;
  int          n_fail = 0;
  int          oe_hits = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_byte = '0;
  logic [7:0]  mon_exp;
  int          mon_bits = 0;

  flash_spi_target #(.ADDR_BITS(16)) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_SPI_nCS     (ncs),
    .i_SPI_Clk     (sck),
    .i_SPI_MOSI    (mosi),
    .o_SPI_MISO    (miso),
    .o_SPI_MISO_OE (oe),
    .o_Mem_Addr    (maddr),
    .o_Mem_Rd      (mrd),
    .o_Mem_Wr      (mwr),
    .o_Mem_WrData  (wdata),
    .i_Mem_RdData  (rdata),
    .o_Busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (mwr) begin
      mem[maddr] <= wdata;
    end
    if (mrd) rdata <= mem[maddr];
    if (mwr) wr_cnt <= wr_cnt + 1;
  end

  // Controller-side monitor: samples MISO on SPI rising edges
  always @(posedge sck or posedge ncs) begin
    if (ncs) begin
      mon_bits = 0;
    end else if (oe) begin
      oe_hits++;
      mon_byte = {mon_byte[6:0], miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL miso_unexpected got %h exp none", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_byte !== mon_exp) begin
            n_fail++;
            $display("FAIL miso_byte got %h exp %h", mon_byte, mon_exp);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      #80 sck = 1'b1;
      #80 sck = 1'b0;
    end
  endtask

  task automatic cs_lo();
    @(negedge clk);
    ncs = 1'b0;
    #80;
  endtask

  task automatic cs_hi();
    #80 ncs = 1'b1;
    #160;
  endtask

  task automatic cmd8(input logic [7:0] op);
    cs_lo();
    bits(32'(op), 8);
    cs_hi();
  endtask

  task automatic rdsr(input logic [7:0] e);
    exp_q.push_back(e);
    cs_lo();
    bits(32'h05, 8);
    bits(32'h00, 8);
    cs_hi();
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  int base;
  int h;

  initial begin
    preload = 1'b1;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    chk("reset_spi", {29'b0, miso, oe, busy}, 32'h0);
    chk("reset_mem_strobe", {30'b0, mrd, mwr}, 32'h0);
    chk("reset_mem_bus", {8'h0, wdata, maddr}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    cmd8(8'h06);
    rdsr(8'h02);
    cmd8(8'h04);
    rdsr(8'h00);

    exp_q.push_back(8'hA4);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5B);
    cs_lo();
    bits(32'h03, 8);
    bits(32'h00FFFE, 24);
    bits(32'h0, 32);
    cs_hi();

    poke(16'h00FF, 8'h3C);
    poke(16'h0000, 8'hFF);
    cmd8(8'h06);
    cs_lo();
    bits(32'h02, 8);
    bits(32'h0000FF, 24);
    bits(32'h0F, 8);
    bits(32'hF0, 8);
    cs_hi();
    chk("pp_and_ff", 32'(mem[16'h00FF]), 32'h0C);
    chk("pp_wrap_00", 32'(mem[16'h0000]), 32'hF0);
    chk("pp_next_page", 32'(mem[16'h0100]), 32'h5A);
    rdsr(8'h00);

    cmd8(8'h06);
    cs_lo();
    bits(32'h20, 8);
    bits(32'h001234, 24);
    cs_hi();
    chk("se_busy", 32'(busy), 32'h1);
    rdsr(8'h03);
    for (int i = 0; i < 6000 && busy; i++) @(negedge clk);
    chk("se_done", 32'(busy), 32'h0);
    chk("se_lo", 32'(mem[16'h1000]), 32'hFF);
    chk("se_mid", 32'(mem[16'h1234]), 32'hFF);
    chk("se_hi", 32'(mem[16'h1FFF]), 32'hFF);
    chk("se_below", 32'(mem[16'h0FFF]), 32'hA5);
    chk("se_above", 32'(mem[16'h2000]), 32'h5A);
    rdsr(8'h00);

    base = wr_cnt;
    cs_lo();
    bits(32'h02, 8);
    bits(32'h000010, 24);
    bits(32'h00, 8);
    cs_hi();
    chk("pp_nowel_mem", 32'(mem[16'h0010]), 32'h4A);
    chk("pp_nowel_wr", 32'(wr_cnt - base), 32'h0);

    cmd8(8'h06);
    cs_lo();
    bits(32'h20, 8);
    bits(32'h001000, 23);
    cs_hi();
    repeat (20) @(negedge clk);
    chk("se31_busy", 32'(busy), 32'h0);
    chk("se31_wr", 32'(wr_cnt - base), 32'h0);
    rdsr(8'h02);

    cmd8(8'hC7);
    chk("ce_busy", 32'(busy), 32'h1);
    h = oe_hits;
    cs_lo();
    bits(32'h03, 8);
    bits(32'h0, 24);
    bits(32'h0, 16);
    cs_hi();
    chk("read_busy_oe", 32'(oe_hits - h), 32'h0);

    for (int i = 0; i < 70000 && (wr_cnt - base) < 32768; i++)
      @(negedge clk);
    chk("ce_half", 32'((wr_cnt - base) >= 32768), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    h = wr_cnt;
    repeat (100) @(negedge clk);
    chk("abort_no_wr", 32'(wr_cnt - h), 32'h0);
    chk("abort_erased", 32'(mem[16'h0000]), 32'hFF);
    chk("abort_kept", 32'(mem[16'hFFFF]), 32'hA5);
    rdsr(8'h00);

    repeat (10) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
